// File: rtl/game_timer_pkg.sv
// Purpose: shared time width, saturation default and state encoding for the game timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_timer_pkg;

   // Width of the seconds field carried to the display.
   localparam int TIME_W = 12;

   // 59:59 expressed in seconds; fits the 6-bit minutes field downstream.
   localparam int MAX_SECONDS_DEFAULT = 3599;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Purpose: divides the system clock down to a one-second tick; counts only while enabled.
// Latency: tick_o is combinational, high during the last cycle of each second.
// Backpressure: none; en_i low holds the partial second, clr_i zeroes it.
//
// Ports:
//   clk_i   system clock (rising edge)
//   rst_ni  asynchronous active-low reset
//   en_i    count enable (timer running)
//   clr_i   synchronous clear, dominates en_i
//   tick_o  one-cycle pulse while the count sits at CLKS_PER_SEC-1 and is enabled
module tick_prescaler #(
   parameter int CLKS_PER_SEC = 50000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_SEC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_timer_controller.sv
// Purpose: game clock FSM (IDLE/RUN/PAUSE/DONE) with a saturating seconds register.
// Latency: num_seconds/sec_tick/expired update one cycle after the tick or command edge.
// Backpressure: none; command pulses are acted on immediately, priority clear > start > pause.
//
// Ports:
//   clock, resetn        system clock; asynchronous active-low reset
//   start, pause, clear  one-cycle command pulses
//   load_seconds         countdown start value (used only with GAME_TIMER_COUNTDOWN_EN)
//   num_seconds          registered current time
//   running              high while in RUN
//   sec_tick             one-cycle pulse on every num_seconds update
//   expired              one-cycle pulse on entry to DONE
//
// Build option: define GAME_TIMER_COUNTDOWN_EN to count down from load_seconds to 0;
// otherwise the timer counts up from 0 to MAX_SECONDS.
module game_timer_controller
   import game_timer_pkg::*;
#(
   parameter int CLKS_PER_SEC = 50000000,
   parameter int MAX_SECONDS  = MAX_SECONDS_DEFAULT
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic              pause,
   input  logic              clear,
   input  logic [TIME_W-1:0] load_seconds,
   output logic [TIME_W-1:0] num_seconds,
   output logic              running,
   output logic              sec_tick,
   output logic              expired
);

   localparam logic [TIME_W-1:0] MAX_VAL = TIME_W'(MAX_SECONDS);

   state_e            state_q, state_d;
   logic [TIME_W-1:0] num_q, num_d;
   logic              sec_tick_q, sec_tick_d;
   logic              expired_q, expired_d;

   logic              idle_or_done;
   logic              launch;
   logic              pre_en;
   logic              pre_clr;
   logic              tick;

   assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);

   // A fresh run (from IDLE or DONE) always begins on a whole second; a resume
   // from PAUSE keeps the partial second, so only launch/clear zero the prescaler.
   assign launch  = start & ~clear & idle_or_done;
   assign pre_en  = (state_q == ST_RUN);
   assign pre_clr = clear | launch;

   tick_prescaler #(
      .CLKS_PER_SEC (CLKS_PER_SEC)
   ) u_tick_prescaler (
      .clk_i  (clock),
      .rst_ni (resetn),
      .en_i   (pre_en),
      .clr_i  (pre_clr),
      .tick_o (tick)
   );

`ifdef GAME_TIMER_COUNTDOWN_EN
   logic [TIME_W-1:0] load_sat;
   assign load_sat = (load_seconds > MAX_VAL) ? MAX_VAL : load_seconds;
`else
   logic unused_load;
   assign unused_load = ^load_seconds;
`endif

   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      sec_tick_d = 1'b0;
      expired_d  = 1'b0;

      if (clear) begin
         state_d = ST_IDLE;
         num_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
`ifdef GAME_TIMER_COUNTDOWN_EN
                  num_d = load_sat;
                  // Nothing to count: go straight to DONE without a tick.
                  if (load_sat == '0) begin
                     state_d   = ST_DONE;
                     expired_d = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
`else
                  num_d   = '0;
                  state_d = ST_RUN;
`endif
               end
            end

            ST_RUN: begin
               if (tick) begin
                  sec_tick_d = 1'b1;
`ifdef GAME_TIMER_COUNTDOWN_EN
                  if (num_q <= 1) begin
                     num_d     = '0;
                     state_d   = ST_DONE;
                     expired_d = 1'b1;
                  end else begin
                     num_d = num_q - 1'b1;
                  end
`else
                  // Compare with >= so the register can never pass the limit.
                  if (num_q >= MAX_VAL - 1'b1) begin
                     num_d     = MAX_VAL;
                     state_d   = ST_DONE;
                     expired_d = 1'b1;
                  end else begin
                     num_d = num_q + 1'b1;
                  end
`endif
               end
               // Reaching the limit wins over a coincident pause.
               if (pause && (state_d == ST_RUN)) begin
                  state_d = ST_PAUSE;
               end
            end

            ST_PAUSE: begin
               if (start) begin
                  state_d = ST_RUN;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         num_q      <= '0;
         sec_tick_q <= 1'b0;
         expired_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         sec_tick_q <= sec_tick_d;
         expired_q  <= expired_d;
      end
   end

   assign num_seconds = num_q;
   assign running     = (state_q == ST_RUN);
   assign sec_tick    = sec_tick_q;
   assign expired     = expired_q;

endmodule

// File: doc/game_timer_controller.md
GAME_TIMER_CONTROLLER -- requirements
Module: game_timer_controller

Interface
REQ-001 SHALL have parameter: CLKS_PER_SEC, 50000000, clock cycles per one-second tick (>=2).
REQ-002 SHALL have parameter: MAX_SECONDS, 3599, saturation limit (59:59, fits 6-bit minutes field downstream).
REQ-003 SHALL have port: clock  input  1  single system clock, all logic rising-edge.
REQ-004 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  one-cycle pulse; begin/resume/restart.
REQ-006 SHALL have port: pause  input  1  one-cycle pulse; suspend counting.
REQ-007 SHALL have port: clear  input  1  one-cycle pulse; return to IDLE.
REQ-008 SHALL have port: load_seconds  input  12  countdown start value, sampled on start from IDLE/DONE.
REQ-009 SHALL have port: num_seconds  output  12  current time, registered; feeds the time display.
REQ-010 SHALL have port: running  output  1  high while state is RUN.
REQ-011 SHALL have port: sec_tick  output  1  one-cycle pulse on every num_seconds update.
REQ-012 SHALL have port: expired  output  1  one-cycle pulse on entry to DONE.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE.
- IDLE: start -> RUN.
- RUN: pause -> PAUSE; limit reached -> DONE.
- PAUSE: start -> RUN.
- DONE: start -> RUN.
- Any state: clear -> IDLE.
REQ-014 SHALL give input priority clear > start > pause when pulses coincide; start in RUN and pause outside RUN SHALL be ignored.
REQ-015 SHALL run a prescaler 0..CLKS_PER_SEC-1 only in RUN; at CLKS_PER_SEC-1 it wraps to 0 and raises an internal tick.
REQ-016 SHALL hold the prescaler value in PAUSE (resume continues the partial second) and zero it on entry to RUN from IDLE/DONE and on clear.
REQ-017 SHALL, on each tick, update num_seconds and assert sec_tick, both visible the cycle after the tick edge.
REQ-018 SHALL, in count-up mode, start from 0 and increment by 1 per tick; reaching MAX_SECONDS -> DONE with expired, num_seconds held at MAX_SECONDS.
REQ-019 SHALL never let num_seconds exceed MAX_SECONDS or wrap.
REQ-020 SHALL on clear set num_seconds to 0 and deassert running the following cycle.
REQ-021 SHALL restart from DONE exactly as from IDLE: value reloaded, prescaler zeroed.
REQ-022 SHALL assert expired exactly once per DONE entry; sec_tick and expired MAY coincide on the final tick.

Reset
REQ-023 SHALL, on resetn low, immediately and asynchronously force: state IDLE, prescaler 0, num_seconds 0, running 0, sec_tick 0, expired 0.
REQ-024 SHALL ignore start/pause/clear during reset and resume normal operation on the first clock edge after resetn deasserts; reset mid-RUN discards the partial second.

Configuration
REQ-025 SHALL support macro GAME_TIMER_COUNTDOWN_EN.
- Defined: start from IDLE/DONE loads min(load_seconds, MAX_SECONDS) and decrements per tick; reaching 0 -> DONE with expired.
- Defined: start with load_seconds=0 enters DONE the next cycle with expired and no sec_tick.
REQ-026 SHALL, without GAME_TIMER_COUNTDOWN_EN, count up only; load_seconds SHALL be unused.

Structure
REQ-027 SHALL take the state enumeration, the MAX_SECONDS default and the 12-bit time width constant from shared package game_timer_pkg.
REQ-028 SHALL place the prescaler in sub-module tick_prescaler (enable, clear, tick out); state machine and seconds register stay in the top.

Verification
REQ-029 SHALL cover count-up timing: CLKS_PER_SEC=4, start -> sec_tick every 4 cycles, num_seconds 0,1,2,3; first tick 4 cycles after RUN entry.
REQ-030 SHALL cover pause/resume: pause 2 cycles into a second, hold 10 cycles, start -> next tick after 2 more cycles; num_seconds unchanged while paused.
REQ-031 SHALL cover saturation: MAX_SECONDS=5 -> num_seconds reaches 5, expired one pulse, state DONE, no further ticks.
REQ-032 SHALL cover countdown (macro defined): load_seconds=3 -> 3,2,1,0 then expired; load_seconds=4000 -> starts at 3599; load_seconds=0 -> expired next cycle.
REQ-033 SHALL cover priority: clear+start same cycle in RUN -> IDLE, num_seconds 0; start+pause in PAUSE -> RUN.
REQ-034 SHALL cover async reset: resetn low mid-cycle in RUN -> all outputs 0 before the next clock edge; start after release behaves as from IDLE.
